// File: rtl/rc4_pkg.sv
// Shared RC4 definitions used by the init, key-scheduling and PRGA stages.
// Holds the KSA state encoding and the default key/memory-latency parameters.
package rc4_pkg;

  localparam int RC4_N         = 256;
  localparam int RC4_KEY_BYTES = 3;
  localparam int RC4_READ_WAIT = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_I,
    ST_WAIT_I,
    ST_CAP_I,
    ST_RD_J,
    ST_WAIT_J,
    ST_CAP_J,
    ST_WR_I,
    ST_WR_J,
    ST_NEXT,
    ST_DONE
  } ksa_state_t;

endpackage

// File: rtl/rc4_ksa_if.sv
// Control and S-memory bus of the key-scheduling stage.
// master = the KSA (drives the memory), slave = the surrounding controller/memory.
interface rc4_ksa_if
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = RC4_KEY_BYTES
);
  logic                   start;
  logic [8*KEY_BYTES-1:0] secret_key;
  logic                   busy;
  logic                   done;
  logic [7:0]             addr;
  logic [7:0]             rddata;
  logic [7:0]             wrdata;
  logic                   wren;

  modport master (
    input  start, secret_key, rddata,
    output busy, done, addr, wrdata, wren
  );

  modport slave (
    output start, secret_key, rddata,
    input  busy, done, addr, wrdata, wren
  );
endinterface

// File: rtl/rc4_key_byte_sel.sv
// Picks key byte kidx from the registered key; byte 0 is the most significant byte.
module rc4_key_byte_sel #(
  parameter int KEY_BYTES = 3,
  parameter int KW        = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
  input  logic [8*KEY_BYTES-1:0] i_key,
  input  logic [KW-1:0]          i_kidx,
  output logic [7:0]             o_byte
);

  always_comb begin
    o_byte = 8'h00;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (i_kidx == KW'(k)) o_byte = i_key[8*(KEY_BYTES-1-k) +: 8];
    end
  end

endmodule

// File: rtl/rc4_ksa.sv
// RC4 key-scheduling FSM: permutes the shared S memory in place with the secret key.
// State table:
//   IDLE   | waiting for start after reset
//   RD_I   | drive addr=i
//   WAIT_I | memory latency for S[i] (READ_WAIT cycles)
//   CAP_I  | capture S[i], update j
//   RD_J   | drive addr=j
//   WAIT_J | memory latency for S[j] (READ_WAIT cycles)
//   CAP_J  | capture S[j]
//   WR_I   | write S[j] to address i
//   WR_J   | write S[i] to address j
//   NEXT   | advance i/kidx or finish
//   DONE   | permutation complete, done held, PRGA may start
module rc4_ksa
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = RC4_KEY_BYTES,
  parameter int READ_WAIT = RC4_READ_WAIT
) (
  input  logic     clk,
  input  logic     reset,
  rc4_ksa_if.master bus
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int WW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  ksa_state_t             r_state;
  logic [8*KEY_BYTES-1:0] r_key;
  logic [7:0]             r_i;
  logic [7:0]             r_j;
  logic [KW-1:0]          r_kidx;
  logic [7:0]             r_s_i;
  logic [7:0]             r_s_j;
  logic [WW-1:0]          r_wait;
  logic                   r_busy;
  logic                   r_done;
  logic [7:0]             r_addr;
  logic [7:0]             r_wrdata;
  logic                   r_wren;
  logic [7:0]             w_kbyte;

  rc4_key_byte_sel #(
    .KEY_BYTES (KEY_BYTES),
    .KW        (KW)
  ) u_key_sel (
    .i_key  (r_key),
    .i_kidx (r_kidx),
    .o_byte (w_kbyte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_key    <= '0;
      r_i      <= 8'd0;
      r_j      <= 8'd0;
      r_kidx   <= '0;
      r_s_i    <= 8'd0;
      r_s_j    <= 8'd0;
      r_wait   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_addr   <= 8'd0;
      r_wrdata <= 8'd0;
      r_wren   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_addr <= 8'd0;
          r_wren <= 1'b0;
          if (bus.start) begin
            r_key   <= bus.secret_key;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_kidx  <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RD_I;
          end
        end
        ST_RD_I: begin
          r_addr  <= r_i;
          r_wren  <= 1'b0;
          r_wait  <= WW'(READ_WAIT - 1);
          r_state <= (READ_WAIT == 0) ? ST_CAP_I : ST_WAIT_I;
        end
        ST_WAIT_I: begin
          if (r_wait == '0) r_state <= ST_CAP_I;
          else              r_wait  <= r_wait - 1'b1;
        end
        ST_CAP_I: begin
          r_s_i   <= bus.rddata;
          r_j     <= r_j + bus.rddata + w_kbyte;
          r_state <= ST_RD_J;
        end
        ST_RD_J: begin
          r_addr  <= r_j;
          r_wait  <= WW'(READ_WAIT - 1);
          r_state <= (READ_WAIT == 0) ? ST_CAP_J : ST_WAIT_J;
        end
        ST_WAIT_J: begin
          if (r_wait == '0) r_state <= ST_CAP_J;
          else              r_wait  <= r_wait - 1'b1;
        end
        ST_CAP_J: begin
          r_s_j   <= bus.rddata;
          r_state <= ST_WR_I;
        end
        // Both reads are complete here, so i==j simply writes the same value twice.
        ST_WR_I: begin
          r_addr   <= r_i;
          r_wrdata <= r_s_j;
          r_wren   <= 1'b1;
          r_state  <= ST_WR_J;
        end
        ST_WR_J: begin
          r_addr   <= r_j;
          r_wrdata <= r_s_i;
          r_wren   <= 1'b1;
          r_state  <= ST_NEXT;
        end
        ST_NEXT: begin
          r_wren <= 1'b0;
          if (r_i == 8'(RC4_N - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_i     <= r_i + 8'd1;
            r_kidx  <= (r_kidx == KW'(KEY_BYTES - 1)) ? '0 : r_kidx + 1'b1;
            r_state <= ST_RD_I;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.addr   = r_addr;
  assign bus.wrdata = r_wrdata;
  assign bus.wren   = r_wren;

endmodule

// File: tb/tb_rc4_ksa.sv
// Directed bench for rc4_ksa with a 2-cycle synchronous S memory model
// and a behavioural KSA reference.
module tb_rc4_ksa;
  import rc4_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rc4_ksa_if #(.KEY_BYTES(3)) bus ();

  rc4_ksa #(.KEY_BYTES(3), .READ_WAIT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] mem [256];
  logic [7:0] rd_p1;
  logic       init_req = 1'b0;
  logic       clr_log  = 1'b0;
  int         wr_cnt   = 0;
  logic [7:0] log_a [6];
  logic [7:0] log_d [6];
  logic [7:0] exp_s [256];

  // Memory model: two-stage read pipeline, write on wren, plus a log of the first writes.
  always @(posedge clk) begin
    rd_p1      <= mem[bus.addr];
    bus.rddata <= rd_p1;
    if (init_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bus.wren) begin
      mem[bus.addr] <= bus.wrdata;
    end
    if (clr_log) wr_cnt <= 0;
    else if (bus.wren) begin
      if (wr_cnt < 6) begin
        log_a[wr_cnt] <= bus.addr;
        log_d[wr_cnt] <= bus.wrdata;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic prep();
    @(negedge clk);
    init_req = 1'b1;
    clr_log  = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    clr_log  = 1'b0;
  endtask

  // Reference KSA applied in place to exp_s.
  task automatic ksa_model(input logic [23:0] key);
    logic [7:0] j, t, kb;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = key[8*(2 - (i % 3)) +: 8];
      j  = j + exp_s[i] + kb;
      t  = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
    end
  endtask

  task automatic run_ksa(input logic [23:0] key, input bit disturb, input int rst_at,
                         output int cyc, output logic busy_pre, output logic done_acc);
    @(negedge clk);
    bus.secret_key = key;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    done_acc  = bus.done;
    cyc       = 0;
    busy_pre  = 1'b0;
    while (!bus.done && cyc < 4000) begin
      busy_pre = bus.busy;
      @(posedge clk);
      #1;
      cyc++;
      if (disturb && cyc == 100) bus.start = 1'b1;
      if (disturb && cyc == 101) bus.start = 1'b0;
      if (disturb && cyc == 200) bus.secret_key = 24'hDEAD01;
      if (rst_at != 0 && cyc == rst_at) begin
        reset = 1'b0;
        #1;
        chk("abort_wren", 32'(bus.wren), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        return;
      end
    end
  endtask

  task automatic chk_first_writes();
    logic [7:0] ea [6];
    logic [7:0] ed [6];
    ea = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3};
    ed = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2};
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("wr%0d_addr", k), 32'(log_a[k]), 32'(ea[k]));
      chk($sformatf("wr%0d_data", k), 32'(log_d[k]), 32'(ed[k]));
    end
  endtask

  task automatic chk_s(input string tag);
    bit seen [256];
    int dup;
    dup = 0;
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    for (int k = 0; k < 256; k++) begin
      chk($sformatf("%s_s%0d", tag, k), 32'(mem[k]), 32'(exp_s[k]));
      if (seen[mem[k]]) dup++;
      seen[mem[k]] = 1'b1;
    end
    chk({tag, "_perm_dups"}, 32'(dup), 32'd0);
  endtask

  int   cyc;
  logic busy_pre, done_acc;

  initial begin
    bus.start      = 1'b0;
    bus.secret_key = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(bus.busy),   32'd0);
    chk("rst_done",   32'(bus.done),   32'd0);
    chk("rst_wren",   32'(bus.wren),   32'd0);
    chk("rst_addr",   32'(bus.addr),   32'd0);
    chk("rst_wrdata", 32'(bus.wrdata), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Zero key on identity S: first writes, latency, write count.
    prep();
    run_ksa(24'h000000, 1'b0, 0, cyc, busy_pre, done_acc);
    chk("k0_cycles",   32'(cyc),      32'd2816);
    chk("k0_busy_pre", 32'(busy_pre), 32'd1);
    chk("k0_busy_end", 32'(bus.busy), 32'd0);
    chk("k0_done",     32'(bus.done), 32'd1);
    chk("k0_wren_cnt", 32'(wr_cnt),   32'd512);
    chk_first_writes();

    // Real key against the reference model.
    prep();
    for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
    ksa_model(24'h4A6F65);
    run_ksa(24'h4A6F65, 1'b0, 0, cyc, busy_pre, done_acc);
    chk("key_cycles", 32'(cyc), 32'd2816);
    chk_s("key");

    // Same key with start and secret_key disturbed mid-run.
    prep();
    run_ksa(24'h4A6F65, 1'b1, 0, cyc, busy_pre, done_acc);
    chk("dist_cycles", 32'(cyc), 32'd2816);
    chk_s("dist");

    // Abort by reset, then a clean zero-key run.
    prep();
    run_ksa(24'h4A6F65, 1'b0, 1500, cyc, busy_pre, done_acc);
    @(negedge clk);
    reset = 1'b1;
    prep();
    run_ksa(24'h000000, 1'b0, 0, cyc, busy_pre, done_acc);
    chk("rerun_cycles", 32'(cyc), 32'd2816);
    chk_first_writes();

    // Restart from DONE with a new key, starting from the already-permuted S.
    for (int k = 0; k < 256; k++) exp_s[k] = mem[k];
    ksa_model(24'h0000FF);
    @(negedge clk);
    clr_log = 1'b1;
    @(negedge clk);
    clr_log = 1'b0;
    run_ksa(24'h0000FF, 1'b0, 0, cyc, busy_pre, done_acc);
    chk("restart_done_drop", 32'(done_acc), 32'd0);
    chk("restart_cycles",    32'(cyc),      32'd2816);
    chk("restart_wren_cnt",  32'(wr_cnt),   32'd512);
    chk_s("restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
